// File: rtl/axi4s_demux_buf_pkg.sv
// Shared types and helpers for the buffered AXI4-Stream demultiplexer.
//   release_state_e : per-stream packet release state (IDLE / RELEASE)
//   ptr_width()     : FIFO pointer width, one extra MSB to tell full from empty
package axi4s_demux_buf_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RELEASE = 1'b1
    } release_state_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi4s_sync_fifo.sv
// Single-clock FIFO with registered storage.
// Full and empty are derived from pointers carrying one extra MSB.
// The head word is always presented on rd_data. It is valid whenever !empty.
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_en, wr_data   : push (ignored while full)
//   full             : no free slot
//   rd_en, rd_data   : pop (ignored while empty), head word
//   empty            : no stored word
module axi4s_sync_fifo
    import axi4s_demux_buf_pkg::*;
#(
    parameter int data_width_p = 8,
    parameter int depth_p      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [data_width_p-1:0] wr_data,
    output logic                    full,
    input  logic                    rd_en,
    output logic [data_width_p-1:0] rd_data,
    output logic                    empty
);

    localparam int ptr_w  = ptr_width(depth_p);
    localparam int addr_w = ptr_w - 1;

    logic [ptr_w-1:0]        wr_ptr;
    logic [ptr_w-1:0]        rd_ptr;
    logic [data_width_p-1:0] mem [depth_p];

    // The pointers share their address bits when the FIFO is full or empty.
    // The MSB tells the two cases apart: it differs when full and matches when empty.
    assign full    = (wr_ptr[addr_w] != rd_ptr[addr_w]) &&
                     (wr_ptr[addr_w-1:0] == rd_ptr[addr_w-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[addr_w-1:0]];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // NOTE: storage is reset because the head word drives egress data, which must read 0 out of reset.
            for (int i = 0; i < depth_p; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en && !full) begin
                mem[wr_ptr[addr_w-1:0]] <= wr_data;
                wr_ptr                  <= wr_ptr + ptr_w'(1);
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
        end
    end

endmodule

// File: rtl/axi4s_demux_buf.sv
// Buffered AXI4-Stream demultiplexer.
// Each ingress beat is steered by tid into its own per-stream FIFO.
// A stalled consumer therefore blocks only its own stream.
// With packet_mode_p=1, a stream is released only once a whole tlast-terminated packet is buffered.
// A draining escape handles packets longer than the FIFO.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   axi4s_i_*                    : shared ingress (tvalid/tready/tlast/tid/tdata)
//   axi4s_o_*                    : per-stream egress, one lane per stream
//   tid_err_o                    : one-cycle pulse after an out-of-range tid beat is dropped
module axi4s_demux_buf
    import axi4s_demux_buf_pkg::*;
#(
    parameter int nr_of_streams_p = 4,
    parameter int tdata_width_p   = 3,
    parameter int fifo_depth_p    = 8,
    parameter int packet_mode_p   = 0
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    output logic                                             axi4s_i_tready,
    input  logic                                             axi4s_i_tvalid,
    input  logic                                             axi4s_i_tlast,
    input  logic [$clog2(nr_of_streams_p)-1:0]               axi4s_i_tid,
    input  logic [tdata_width_p*8-1:0]                       axi4s_i_tdata,
    input  logic [nr_of_streams_p-1:0]                       axi4s_o_tready,
    output logic [nr_of_streams_p-1:0]                       axi4s_o_tvalid,
    output logic [nr_of_streams_p-1:0]                       axi4s_o_tlast,
    output logic [nr_of_streams_p-1:0][tdata_width_p*8-1:0]  axi4s_o_tdata,
    output logic                                             tid_err_o
);

    localparam int tid_w  = $clog2(nr_of_streams_p);
    localparam int data_w = tdata_width_p * 8;
    localparam int cnt_w  = ptr_width(fifo_depth_p);

    logic [nr_of_streams_p-1:0]           sel;
    logic                                 tid_in_range;
    logic [nr_of_streams_p-1:0]           full;
    logic [nr_of_streams_p-1:0]           empty;
    logic [nr_of_streams_p-1:0]           wr_en;
    logic [nr_of_streams_p-1:0]           pop;
    logic [nr_of_streams_p-1:0]           head_last;
    logic [nr_of_streams_p-1:0][data_w:0] head_word;

    // The tid decode is one-hot, so a non-power-of-two stream count leaves
    // the unused tid codes with no select bit set. Those beats count as out of range.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel = '0;
        for (int i = 0; i < nr_of_streams_p; i++) begin
            if (axi4s_i_tid == tid_w'(i)) begin
                sel[i] = 1'b1;
            end
        end
        tid_in_range   = |sel;
        // No pass-through: a pop in the same cycle does not open a full FIFO.
        axi4s_i_tready = tid_in_range ? |(sel & ~full) : 1'b1;
    end

    assign wr_en = {nr_of_streams_p{axi4s_i_tvalid && axi4s_i_tready}} & sel;
    assign pop   = axi4s_o_tvalid & axi4s_o_tready;

    // Out-of-range beats are always accepted (ready=1) and then dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tid_err_o <= 1'b0;
        end else begin
            tid_err_o <= axi4s_i_tvalid && !tid_in_range;
        end
    end

    for (genvar g = 0; g < nr_of_streams_p; g++) begin : g_stream

        axi4s_sync_fifo #(
            .data_width_p (data_w + 1),
            .depth_p      (fifo_depth_p)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[g]),
            .wr_data ({axi4s_i_tlast, axi4s_i_tdata}),
            .full    (full[g]),
            .rd_en   (pop[g]),
            .rd_data (head_word[g]),
            .empty   (empty[g])
        );

        assign head_last[g]        = head_word[g][data_w];
        assign axi4s_o_tlast[g]    = head_last[g];
        assign axi4s_o_tdata[g]    = head_word[g][data_w-1:0];

        if (packet_mode_p != 0) begin : g_pkt
            // pkt_cnt counts the tlast beats currently held in this FIFO.
            logic [cnt_w-1:0] pkt_cnt;
            logic             draining;
            release_state_e   state;
            logic             wr_last;
            logic             pop_last;

            assign wr_last  = wr_en[g] && axi4s_i_tlast;
            assign pop_last = pop[g] && head_last[g];

            // A full FIFO with no complete packet can never gain one.
            // Release it anyway (draining) until that oversized packet's tlast leaves.
            assign axi4s_o_tvalid[g] = !empty[g] &&
                                       ((pkt_cnt != '0) || full[g] || draining);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pkt_cnt  <= '0;
                    draining <= 1'b0;
                    state    <= IDLE;
                end else begin
                    if (wr_last && !pop_last) begin
                        pkt_cnt <= pkt_cnt + cnt_w'(1);
                    end else if (!wr_last && pop_last) begin
                        pkt_cnt <= pkt_cnt - cnt_w'(1);
                    end

                    if (pop_last) begin
                        draining <= 1'b0;
                    end else if (full[g] && (pkt_cnt == '0)) begin
                        draining <= 1'b1;
                    end

                    case (state)
                        IDLE: begin
                            if ((pkt_cnt != '0) || full[g]) begin
                                state <= RELEASE;
                            end
                        end
                        RELEASE: begin
                            if (pop_last && !wr_last && (pkt_cnt == cnt_w'(1)) && !draining) begin
                                state <= IDLE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end else begin : g_cut
            assign axi4s_o_tvalid[g] = !empty[g];
        end
    end

endmodule

// File: tb/tb_axi4s_demux_buf.sv
// Self-checking bench for axi4s_demux_buf.
// Three instances share one ingress stream:
//   u_ct  : 4 streams, cut-through
//   u_pkt : 4 streams, packet mode
//   u_n3  : 3 streams, cut-through (tid 3 is out of range)
// A queue-based reference model predicts ready, valid, data, last and tid_err.
// These predictions come from the buffering rules.
module tb_axi4s_demux_buf;

    localparam int DEPTH = 8;
    localparam int DW    = 24;
    typedef logic [DW:0] beat_t;   // {tlast, tdata}

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]    i_valid;
    logic          i_last;
    logic [1:0]    i_tid;
    logic [DW-1:0] i_data;
    logic [3:0]    o_ready;

    logic i_ready0, i_ready1, i_ready2;
    logic err0, err1, err2;
    logic [3:0] ov0, ol0, ov1, ol1;
    logic [2:0] ov2, ol2;
    logic [3:0][DW-1:0] od0, od1;
    logic [2:0][DW-1:0] od2;

    axi4s_demux_buf #(.nr_of_streams_p(4), .tdata_width_p(3), .fifo_depth_p(DEPTH), .packet_mode_p(0)) u_ct (
        .clk(clk), .rst_n(rst_n),
        .axi4s_i_tready(i_ready0), .axi4s_i_tvalid(i_valid[0]), .axi4s_i_tlast(i_last),
        .axi4s_i_tid(i_tid), .axi4s_i_tdata(i_data),
        .axi4s_o_tready(o_ready), .axi4s_o_tvalid(ov0), .axi4s_o_tlast(ol0), .axi4s_o_tdata(od0),
        .tid_err_o(err0));

    axi4s_demux_buf #(.nr_of_streams_p(4), .tdata_width_p(3), .fifo_depth_p(DEPTH), .packet_mode_p(1)) u_pkt (
        .clk(clk), .rst_n(rst_n),
        .axi4s_i_tready(i_ready1), .axi4s_i_tvalid(i_valid[1]), .axi4s_i_tlast(i_last),
        .axi4s_i_tid(i_tid), .axi4s_i_tdata(i_data),
        .axi4s_o_tready(o_ready), .axi4s_o_tvalid(ov1), .axi4s_o_tlast(ol1), .axi4s_o_tdata(od1),
        .tid_err_o(err1));

    axi4s_demux_buf #(.nr_of_streams_p(3), .tdata_width_p(3), .fifo_depth_p(DEPTH), .packet_mode_p(0)) u_n3 (
        .clk(clk), .rst_n(rst_n),
        .axi4s_i_tready(i_ready2), .axi4s_i_tvalid(i_valid[2]), .axi4s_i_tlast(i_last),
        .axi4s_i_tid(i_tid), .axi4s_i_tdata(i_data),
        .axi4s_o_tready(o_ready[2:0]), .axi4s_o_tvalid(ov2), .axi4s_o_tlast(ol2), .axi4s_o_tdata(od2),
        .tid_err_o(err2));

    // Uniform view of the three instances.
    logic          obs_rdy [3];
    logic          obs_err [3];
    logic [3:0]    obs_v   [3];
    logic [3:0]    obs_l   [3];
    logic [DW-1:0] obs_d   [3][4];

    always_comb begin
        obs_rdy[0] = i_ready0; obs_rdy[1] = i_ready1; obs_rdy[2] = i_ready2;
        obs_err[0] = err0;     obs_err[1] = err1;     obs_err[2] = err2;
        obs_v[0] = ov0; obs_v[1] = ov1; obs_v[2] = {1'b0, ov2};
        obs_l[0] = ol0; obs_l[1] = ol1; obs_l[2] = {1'b0, ol2};
        for (int s = 0; s < 4; s++) begin
            obs_d[0][s] = od0[s];
            obs_d[1][s] = od1[s];
            obs_d[2][s] = (s < 3) ? od2[s] : '0;
        end
    end

    // Reference model state.
    beat_t      mq     [3][4][$];
    bit         mdrain [3][4];
    bit         exp_err[3];
    int         dlv    [3][4];
    logic [2:0] pending;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nstr(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int count_pkts(input int d, input int s);
        int n = 0;
        for (int i = 0; i < mq[d][s].size(); i++) begin
            if (mq[d][s][i][DW]) n++;
        end
        return n;
    endfunction

    // A stream may present its head when it is non-empty.
    // In packet mode it also needs a complete packet, a full FIFO,
    // or an oversized packet being drained.
    function automatic bit exp_valid(input int d, input int s);
        int sz = mq[d][s].size();
        if (sz == 0) return 1'b0;
        if (d != 1) return 1'b1;
        return (count_pkts(d, s) > 0) || (sz == DEPTH) || mdrain[d][s];
    endfunction

    function automatic bit exp_ready(input int d);
        if (int'(i_tid) >= nstr(d)) return 1'b1;
        return mq[d][i_tid].size() < DEPTH;
    endfunction

    // One clock cycle: drive at the falling edge, check just after it, and update the model after the rising edge.
    task automatic step();
        bit acc  [3];
        bit popm [3][4];
        bit er, ev;
        @(negedge clk);
        i_valid = pending;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("tid_err[%0d]", d), obs_err[d], exp_err[d]);
            er = exp_ready(d);
            check($sformatf("i_tready[%0d] tid=%0d", d, i_tid), obs_rdy[d], er);
            acc[d] = pending[d] && er;
            for (int s = 0; s < 4; s++) begin
                popm[d][s] = 1'b0;
                if (s < nstr(d)) begin
                    ev = exp_valid(d, s);
                    check($sformatf("o_tvalid[%0d][%0d]", d, s), obs_v[d][s], ev);
                    if (ev) begin
                        check($sformatf("o_tdata[%0d][%0d]", d, s), obs_d[d][s], mq[d][s][0][DW-1:0]);
                        check($sformatf("o_tlast[%0d][%0d]", d, s), obs_l[d][s], mq[d][s][0][DW]);
                    end
                    popm[d][s] = ev && o_ready[s];
                    if (obs_v[d][s] && o_ready[s]) dlv[d][s]++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < nstr(d); s++) begin
                if (d == 1) begin
                    if (popm[d][s] && mq[d][s][0][DW]) mdrain[d][s] = 1'b0;
                    else if (mq[d][s].size() == DEPTH && count_pkts(d, s) == 0) mdrain[d][s] = 1'b1;
                end
                if (popm[d][s]) void'(mq[d][s].pop_front());
            end
            if (acc[d] && int'(i_tid) < nstr(d)) mq[d][i_tid].push_back({i_last, i_data});
            exp_err[d] = acc[d] && (int'(i_tid) >= nstr(d));
            if (acc[d]) pending[d] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic start_beat(input logic [1:0] tid, input logic [DW-1:0] data, input logic last);
        i_tid   = tid;
        i_data  = data;
        i_last  = last;
        pending = 3'b111;
    endtask

    // Wait until every instance has taken the beat. A long stall opens all consumers.
    task automatic wait_beat();
        for (int k = 0; k < 300 && pending != 3'b000; k++) begin
            if (k == 20) o_ready = 4'b1111;
            step();
        end
        check("beat_accepted", {29'd0, pending}, 32'd0);
        pending = 3'b000;
    endtask

    task automatic send_beat(input logic [1:0] tid, input logic [DW-1:0] data, input logic last);
        start_beat(tid, data, last);
        wait_beat();
    endtask

    task automatic clear_dlv();
        for (int d = 0; d < 3; d++)
            for (int s = 0; s < 4; s++) dlv[d][s] = 0;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            exp_err[d] = 1'b0;
            for (int s = 0; s < 4; s++) begin
                mq[d][s].delete();
                mdrain[d][s] = 1'b0;
            end
        end
        pending = 3'b000;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s err[%0d]", tag, d), obs_err[d], 0);
            for (int s = 0; s < nstr(d); s++) begin
                check($sformatf("%s tvalid[%0d][%0d]", tag, d, s), obs_v[d][s], 0);
                check($sformatf("%s tlast[%0d][%0d]", tag, d, s), obs_l[d][s], 0);
                check($sformatf("%s tdata[%0d][%0d]", tag, d, s), obs_d[d][s], 0);
            end
        end
    endtask

    task automatic random_traffic(input int n);
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < 4; s++) o_ready[s] = ($urandom_range(3) != 0);
            if ($urandom_range(3) == 0) step();
            else send_beat(2'($urandom_range(3)), DW'($urandom), ($urandom_range(3) == 0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        i_valid = 3'b000;
        i_tid   = '0;
        i_data  = '0;
        i_last  = 1'b0;
        o_ready = 4'b0000;
        clear_model();
        clear_dlv();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Cut-through: 10 beats to each tid, data 1..40, all consumers ready.
        o_ready = 4'b1111;
        for (int n = 1; n <= 40; n++) send_beat(2'((n - 1) % 4), DW'(n), (n > 36));
        idle(20);
        for (int d = 0; d < 3; d++)
            for (int s = 0; s < nstr(d); s++) check($sformatf("ct_count[%0d][%0d]", d, s), dlv[d][s], 10);

        // Backpressure isolation on stream 2, interleaved with stream 0.
        clear_dlv();
        o_ready = 4'b1011;
        for (int k = 0; k < 8; k++) begin
            send_beat(2'd2, DW'(100 + k), 1'b0);
            send_beat(2'd0, DW'(200 + k), 1'b0);
        end
        start_beat(2'd2, DW'(108), 1'b0);
        idle(4);
        check("bp_held", {29'd0, pending}, 32'd7);
        check("bp_stream0", dlv[0][0], 8);
        o_ready = 4'b1111;
        wait_beat();
        for (int k = 9; k < 12; k++) send_beat(2'd2, DW'(100 + k), (k == 11));
        for (int k = 8; k < 12; k++) send_beat(2'd0, DW'(200 + k), (k == 11));
        idle(20);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("bp_s2_count[%0d]", d), dlv[d][2], 12);
            check($sformatf("bp_s0_count[%0d]", d), dlv[d][0], 12);
        end

        // Packet mode: 4-beat packet on tid 1 with 2-cycle gaps.
        clear_dlv();
        for (int k = 0; k < 4; k++) begin
            send_beat(2'd1, DW'(300 + k), (k == 3));
            idle(2);
        end
        idle(8);
        check("pkt4_count", dlv[1][1], 4);

        // Packet mode oversize: 12-beat packet into an 8-deep FIFO.
        clear_dlv();
        for (int k = 0; k < 12; k++) send_beat(2'd2, DW'(400 + k), (k == 11));
        idle(20);
        for (int d = 0; d < 3; d++) check($sformatf("oversize_count[%0d]", d), dlv[d][2], 12);

        // Out-of-range tid on the 3-stream instance.
        clear_dlv();
        send_beat(2'd3, DW'('h55), 1'b1);
        idle(4);
        check("tid3_n3_out", dlv[2][0] + dlv[2][1] + dlv[2][2], 0);
        check("tid3_ct_out", dlv[0][3], 1);

        // Random traffic with random backpressure.
        random_traffic(600);
        o_ready = 4'b1111;
        idle(30);

        // Reset with beats buffered.
        o_ready = 4'b0000;
        for (int k = 0; k < 5; k++) send_beat(2'd1, DW'(500 + k), 1'b0);
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 3'b000;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_dlv();
        o_ready = 4'b1111;
        for (int k = 0; k < 6; k++) send_beat(2'(k % 4), DW'(600 + k), 1'b1);
        idle(5);
        check("post_reset_s0", dlv[0][0], 2);
        check("post_reset_pkt_s1", dlv[1][1], 2);
        random_traffic(150);
        o_ready = 4'b1111;
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
